// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
// Stage indices, fence FSM encoding and the hazard control bundle.
package pipe_ctrl_pkg;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RETIRE = 2'd2
  } fence_st_e;

  typedef struct packed {
    logic       pc_stall;
    logic [3:0] stall;
    logic [3:0] flush;
  } hz_ctl_t;

endpackage

// File: rtl/pipe_ctrl_fence_drain_fsm.sv
// FENCE drain sequencer: IDLE -> DRAIN (count down) -> RETIRE.
// Owns the drain counter and the fence_clr / fence_done pulses.
module fence_drain_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       redirect,
  input  logic       mem_busy,
  output logic       draining,
  output logic       retiring,
  output logic [3:0] fence_clr,
  output logic       fence_done
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  fence_st_e     st, st_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  // An older redirect kills the fence; mem_busy freezes everything.
  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    fence_clr  = '0;
    fence_done = 1'b0;
    if (redirect) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else if (!mem_busy) begin
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            st_n  = ST_DRAIN;
            cnt_n = CW'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (cnt != '0) cnt_n = cnt - CW'(1);
          if (cnt <= CW'(1)) st_n = ST_RETIRE;
        end
        ST_RETIRE: begin
          fence_clr[IF_ID] = 1'b1;
          fence_done       = 1'b1;
          st_n             = ST_IDLE;
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  assign draining = (st == ST_DRAIN);
  assign retiring = (st == ST_RETIRE);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush arbitration for the 5-stage core.
// Optional stall-cycle counter: define PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      id_fence,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_redirect,
  input  logic                      mem_busy,
  input  logic                      if_busy,
  output logic                      pc_stall,
  output logic [3:0]                stall,
  output logic [3:0]                flush,
  output logic [3:0]                fence_clr,
  output logic                      fence_done,
  output logic [31:0]               stall_cycles
);

  logic    load_use;
  logic    draining;
  logic    retiring;
  logic    f_done;
  logic [3:0] f_clr;
  hz_ctl_t ctl;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  fence_drain_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_fence (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (id_fence && !load_use),
    .redirect  (ex_redirect),
    .mem_busy  (mem_busy),
    .draining  (draining),
    .retiring  (retiring),
    .fence_clr (f_clr),
    .fence_done(f_done)
  );

  // Fence start, drain and load-use all hold IF and bubble ID/EX.
  always_comb begin
    ctl = '0;
    if (ex_redirect) begin
      ctl.flush[IF_ID] = 1'b1;
      ctl.flush[ID_EX] = 1'b1;
    end else if (mem_busy) begin
      ctl.stall    = '1;
      ctl.pc_stall = 1'b1;
    end else if (retiring) begin
      ctl = '0;
    end else if (draining || id_fence || load_use) begin
      ctl.pc_stall     = 1'b1;
      ctl.stall[IF_ID] = 1'b1;
      ctl.flush[ID_EX] = 1'b1;
    end else if (if_busy) begin
      ctl.pc_stall     = 1'b1;
      ctl.flush[IF_ID] = 1'b1;
    end
  end

  assign pc_stall   = rst_n & ctl.pc_stall;
  assign stall      = {4{rst_n}} & ctl.stall;
  assign flush      = {4{rst_n}} & ctl.flush;
  assign fence_clr  = {4{rst_n}} & f_clr;
  assign fence_done = rst_n & f_done;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        perf_q <= '0;
    else if (pc_stall) perf_q <= perf_q + 32'd1;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (DRAIN_CYCLES=3).
// Tracks stall_cycles when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, id_fence;
  logic       ex_mem_read, ex_redirect, mem_busy, if_busy;
  logic       pc_stall, fence_done;
  logic [3:0] stall, flush, fence_clr;
  logic [31:0] stall_cycles;

  pipe_ctrl #(
    .DRAIN_CYCLES  (3),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_fence    (id_fence),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .mem_busy    (mem_busy),
    .if_busy     (if_busy),
    .pc_stall    (pc_stall),
    .stall       (stall),
    .flush       (flush),
    .fence_clr   (fence_clr),
    .fence_done  (fence_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 0;
  logic [13:0] obs;

  assign obs = {pc_stall, stall, flush, fence_clr, fence_done};

  task automatic clr_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_fence = 0;
    ex_mem_read = 0; ex_redirect = 0; mem_busy = 0; if_busy = 0;
  endtask

  task automatic chk(input string tag, input logic pc,
                     input logic [3:0] st, input logic [3:0] fl,
                     input logic [3:0] cl, input logic dn);
    exp_t e;
    e.tag = tag;
    e.v   = {pc, st, fl, cl, dn};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s ctl got %h exp %h", e.tag, obs, e.v);
    end
    checks++;
    assert (stall_cycles === model_cnt) else begin
      errors++;
      $error("FAIL %s stall_cycles got %0d exp %0d",
             e.tag, stall_cycles, model_cnt);
    end
    @(posedge clk);
`ifdef PIPE_CTRL_PERF_EN
    if (rst_n && pc) model_cnt = model_cnt + 1;
`endif
    #1;
  endtask

  task automatic hold(input string tag);
    chk(tag, 1, 4'b0001, 4'b0010, 4'b0000, 0);
  endtask

  task automatic zero(input string tag);
    chk(tag, 0, 4'b0000, 4'b0000, 4'b0000, 0);
  endtask

  task automatic done(input string tag);
    chk(tag, 0, 4'b0000, 4'b0000, 4'b0001, 1);
  endtask

  task automatic lu5();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
  endtask

  initial begin
    clr_in();
    rst_n = 0; model_cnt = 0;
    mem_busy = 1; id_fence = 1; if_busy = 1;
    zero("rst_gate0");
    zero("rst_gate1");
    clr_in();
    rst_n = 1;
    zero("idle");

    lu5();
    hold("lu_rs1");
    clr_in();
    zero("lu_advanced");
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
    zero("lu_x0");
    clr_in();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
    hold("lu_rs2");
    id_rs2_used = 0;
    zero("lu_rs2_unused");
    ex_mem_read = 0; id_rs2_used = 1;
    zero("no_load");

    clr_in(); lu5(); ex_redirect = 1;
    chk("redir_lu", 0, 4'b0000, 4'b0011, 4'b0000, 0);
    ex_redirect = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++)
      chk("mem_busy", 1, 4'b1111, 4'b0000, 4'b0000, 0);
    clr_in(); if_busy = 1;
    chk("if_busy", 1, 4'b0000, 4'b0001, 4'b0000, 0);
    lu5();
    hold("if_busy_lu");
    clr_in();

    id_fence = 1;
    hold("fence_T");
    id_fence = 0;
    hold("fence_T1");
    hold("fence_T2");
    hold("fence_T3");
    id_fence = 1;
    done("fence_T4");
    id_fence = 0;
    zero("fence_after");

    id_fence = 1;
    hold("fmb_T");
    id_fence = 0;
    hold("fmb_T1");
    mem_busy = 1;
    chk("fmb_T2", 1, 4'b1111, 4'b0000, 4'b0000, 0);
    chk("fmb_T3", 1, 4'b1111, 4'b0000, 4'b0000, 0);
    mem_busy = 0;
    hold("fmb_T4");
    hold("fmb_T5");
    done("fmb_T6");
    zero("fmb_after");

    id_fence = 1;
    hold("frd_T");
    id_fence = 0;
    hold("frd_T1");
    ex_redirect = 1;
    chk("frd_kill", 0, 4'b0000, 4'b0011, 4'b0000, 0);
    ex_redirect = 0;
    zero("frd_idle0");
    zero("frd_idle1");

    id_fence = 1;
    hold("frt_T");
    id_fence = 0;
    hold("frt_T1");
    hold("frt_T2");
    ex_redirect = 1;
    chk("frt_kill", 0, 4'b0000, 4'b0011, 4'b0000, 0);
    ex_redirect = 0;
    zero("frt_nodone");
    zero("frt_idle");

    id_fence = 1;
    hold("frs_T");
    id_fence = 0;
    hold("frs_T1");
    rst_n = 0; model_cnt = 0;
    zero("frs_rst");
    rst_n = 1;
    for (int i = 0; i < 5; i++)
      zero("frs_nodone");

    if_busy = 1;
    for (int i = 0; i < 5; i++)
      chk("perf_stall", 1, 4'b0000, 4'b0001, 4'b0000, 0);
    clr_in();
    zero("perf_final");
    rst_n = 0; model_cnt = 0;
    #1;
    checks++;
    assert (stall_cycles === model_cnt) else begin
      errors++;
      $error("FAIL perf_async got %0d exp %0d", stall_cycles, model_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
